// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: issues in-order fetches under a credit limit, buffers returned
// words in a small FIFO toward decode, and discards in-flight responses after a redirect.
module fetch_prefetch #(
  parameter int               XLEN      = 32,
  parameter int               DEPTH     = 4,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pcplus4
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

  logic [XLEN-1:0] fq_pc_q    [DEPTH];
  logic [31:0]     fq_instr_q [DEPTH];
  logic [PW-1:0]   fq_head_q, fq_head_d;
  logic [PW-1:0]   fq_tail_q, fq_tail_d;
  logic [CW-1:0]   occ_q, occ_d;

  logic [XLEN-1:0] sq_pc_q [DEPTH];
  logic [PW-1:0]   sq_head_q, sq_head_d;
  logic [PW-1:0]   sq_tail_q, sq_tail_d;

  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] head_pc;

  // Credits count both buffered and in-flight words so a returning response always has a slot.
  assign credit_used    = {1'b0, occ_q} + {1'b0, out_q};
  assign imem_req_valid = (credit_used < DEPTH_C) & ~redirect_valid & ~reset;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses with nothing outstanding belong to requests issued before a reset.
  assign rsp_take = imem_rsp_valid & (out_q != '0) & ~reset;
  assign rsp_drop = rsp_take & (redirect_valid | (drop_q != '0));
  assign push     = rsp_take & ~rsp_drop;

  assign dec_valid   = (occ_q != '0) & ~redirect_valid & ~reset;
  assign pop         = dec_valid & dec_ready;
  assign head_pc     = fq_pc_q[fq_head_q];
  assign dec_pc      = dec_valid ? head_pc : '0;
  assign dec_instr   = dec_valid ? fq_instr_q[fq_head_q] : NOP_INSTR;
  assign dec_pcplus4 = dec_valid ? head_pc + XLEN'(4) : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    fq_head_d  = fq_head_q;
    fq_tail_d  = fq_tail_q;
    occ_d      = occ_q;
    sq_head_d  = sq_head_q;
    sq_tail_d  = sq_tail_q;
    drop_d     = drop_q;
    out_d      = out_q + CW'(req_fire) - CW'(rsp_take);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      fq_head_d  = '0;
      fq_tail_d  = '0;
      occ_d      = '0;
      sq_head_d  = '0;
      sq_tail_d  = '0;
      // Every response still in flight after this edge belongs to the old path.
      drop_d     = out_q - CW'(rsp_take);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        sq_tail_d  = sq_tail_q + PW'(1);
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        fq_tail_d = fq_tail_q + PW'(1);
        sq_head_d = sq_head_q + PW'(1);
      end
      if (pop) begin
        fq_head_d = fq_head_q + PW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      fq_head_q  <= '0;
      fq_tail_q  <= '0;
      occ_q      <= '0;
      sq_head_q  <= '0;
      sq_tail_q  <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fq_head_q  <= fq_head_d;
      fq_tail_q  <= fq_tail_d;
      occ_q      <= occ_d;
      sq_head_q  <= sq_head_d;
      sq_tail_q  <= sq_tail_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  // Storage arrays need no reset; validity is tracked entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      sq_pc_q[sq_tail_q] <= fetch_pc_q;
    end
    if (push) begin
      fq_pc_q[fq_tail_q]    <= sq_pc_q[sq_head_q];
      fq_instr_q[fq_tail_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized bench for fetch_prefetch: a queue-based reference model plus an in-order
// instruction memory with random latency; every output is compared every cycle.
module tb_fetch_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [31:0] dec_pcplus4;

  fetch_prefetch #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_pcplus4(dec_pcplus4)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Stimulus knobs for the next cycle.
  bit          d_reset  = 1'b1;
  bit          d_redir  = 1'b0;
  logic [31:0] d_rpc    = '0;
  bit          d_ready  = 1'b1;
  bit          d_dready = 1'b1;
  int          lat_min  = 1;
  int          lat_max  = 1;

  // Reference model: fetch PC, decode queue of PCs, in-flight requests in issue order.
  logic [31:0] m_fetch = '0;
  logic [31:0] m_fifo[$];
  logic [31:0] inf_pc[$];
  bit          inf_stale[$];
  int          inf_due[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B9) ^ 32'h00C0_FFEE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit          rsp_v, exp_rv, exp_dv, fire, pop, s;
    logic [31:0] exp_pc, exp_in, exp_p4, p;
    @(negedge clk);
    reset          = d_reset;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    imem_req_ready = d_ready;
    dec_ready      = d_dready;
    rsp_v          = (inf_pc.size() > 0) && (inf_due[0] <= cyc);
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? instr_of(inf_pc[0]) : $urandom;
    #1;
    exp_rv = (m_fifo.size() + inf_pc.size() < DEPTH) && !d_redir && !d_reset;
    exp_dv = (m_fifo.size() > 0) && !d_redir && !d_reset;
    exp_pc = exp_dv ? m_fifo[0] : 32'h0;
    exp_in = exp_dv ? instr_of(m_fifo[0]) : NOP;
    exp_p4 = exp_dv ? m_fifo[0] + 32'd4 : 32'h0;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
    chk("dec_valid", {31'b0, dec_valid}, {31'b0, exp_dv});
    chk("dec_pc", dec_pc, exp_pc);
    chk("dec_instr", dec_instr, exp_in);
    chk("dec_pcplus4", dec_pcplus4, exp_p4);
    fire = exp_rv && d_ready;
    pop  = exp_dv && d_dready;
    @(posedge clk);
    if (d_reset) begin
      m_fetch = RESET_PC;
      m_fifo.delete();
      inf_pc.delete();
      inf_stale.delete();
      inf_due.delete();
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (rsp_v) begin
        p = inf_pc.pop_front();
        s = inf_stale.pop_front();
        void'(inf_due.pop_front());
        if (!s && !d_redir) m_fifo.push_back(p);
      end
      if (d_redir) begin
        m_fifo.delete();
        foreach (inf_stale[i]) inf_stale[i] = 1'b1;
        m_fetch = d_rpc;
      end else if (fire) begin
        inf_pc.push_back(m_fetch);
        inf_stale.push_back(1'b0);
        inf_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset, then streaming with 1-cycle memory and decode always ready.
    d_reset = 1; run(3);
    d_reset = 0; d_ready = 1; d_dready = 1; lat_min = 1; lat_max = 1;
    run(12);

    // Decode stall: queue fills to DEPTH, requests stop, head held; then resume.
    d_dready = 0; run(10);
    d_dready = 1; run(8);

    // 3-cycle memory with requests in flight, redirect to 0x100.
    lat_min = 3; lat_max = 3; run(6);
    d_redir = 1; d_rpc = 32'h0000_0100; run(1);
    d_redir = 0; run(12);

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1; run(4);
    d_redir = 1; d_rpc = 32'h0000_0200; run(1);
    d_redir = 0; run(6);

    // Back-to-back redirects with slow memory.
    lat_min = 4; lat_max = 4; run(3);
    d_redir = 1; d_rpc = 32'h0000_0300; run(1);
    d_rpc = 32'h0000_0400; run(1);
    d_redir = 0; run(14);

    // Address wrap at the top of the space.
    lat_min = 1; lat_max = 1;
    d_redir = 1; d_rpc = 32'hFFFF_FFF8; run(1);
    d_redir = 0; run(8);

    // Reset with 3 entries queued and 1 outstanding.
    d_reset = 1; run(1);
    d_reset = 0; lat_min = 3; lat_max = 3; d_dready = 0; run(6);
    d_reset = 1; run(1);
    d_reset = 0; lat_min = 1; lat_max = 1; d_dready = 1; run(8);

    // Unaligned redirect target passes through.
    d_redir = 1; d_rpc = 32'h0000_0123; run(1);
    d_redir = 0; run(6);

    // Randomized traffic.
    for (int seg = 0; seg < 40; seg++) begin
      lat_min = $urandom_range(2, 1);
      lat_max = lat_min + $urandom_range(3, 0);
      for (int i = 0; i < 100; i++) begin
        d_ready  = ($urandom_range(99, 0) < 75);
        d_dready = ($urandom_range(99, 0) < 65);
        d_redir  = ($urandom_range(99, 0) < 4);
        d_rpc    = ($urandom_range(9, 0) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        d_reset  = ($urandom_range(199, 0) == 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameter XLEN, default 32: width of all PC/address ports.
REQ-002 Parameter DEPTH, default 4: fetch-queue entries; SHALL be a power of two, >= 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: fetch PC loaded on reset.
REQ-004 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): value driven on dec_instr when dec_valid=0.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 redirect_valid  input  1  branch/jump taken; load new fetch PC and flush.
REQ-008 redirect_pc  input  XLEN  target PC for redirect.
REQ-009 imem_req_valid  output  1  fetch request valid.
REQ-010 imem_req_ready  input  1  instruction memory accepts request.
REQ-011 imem_req_addr  output  XLEN  fetch address (current fetch PC).
REQ-012 imem_rsp_valid  input  1  instruction word returned; responses arrive in request order, >= 1 cycle after acceptance.
REQ-013 imem_rsp_data  input  32  returned instruction word.
REQ-014 dec_valid  output  1  queue head valid to decode.
REQ-015 dec_ready  input  1  decode accepts head (deasserted by hazard unit to stall).
REQ-016 dec_pc  output  XLEN  PC of head instruction.
REQ-017 dec_instr  output  32  head instruction.
REQ-018 dec_pcplus4  output  XLEN  dec_pc + 4, modulo 2^XLEN.

Function
REQ-019 State: fetch_pc (XLEN), DEPTH-entry FIFO of {pc, instr}, occupancy count (0..DEPTH), outstanding-request count (0..DEPTH), drop count (0..DEPTH).
REQ-020 imem_req_valid SHALL equal (occupancy + outstanding < DEPTH) AND NOT redirect_valid AND NOT reset; counts are registered values (no same-cycle pop credit).
REQ-021 Request handshake (imem_req_valid & imem_req_ready): fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN); outstanding +1; PC of request recorded in an in-order side queue of DEPTH entries.
REQ-022 Response with drop count = 0: {recorded pc, imem_rsp_data} pushed at FIFO tail; outstanding -1; entry visible on dec_* the following cycle (minimum request-to-dec_valid latency = response cycle + 1).
REQ-023 Response with drop count > 0: data discarded, drop count -1, outstanding -1, FIFO unchanged.
REQ-024 dec_valid SHALL equal (occupancy != 0) AND NOT redirect_valid; dec_pc/dec_instr/dec_pcplus4 show FIFO head.
REQ-025 When dec_valid = 0: dec_instr = NOP_INSTR, dec_pc = 0, dec_pcplus4 = 0.
REQ-026 Pop on dec_valid & dec_ready; simultaneous push and pop leaves occupancy unchanged; the credit rule of REQ-020 guarantees no push when full, and overflow SHALL be impossible.
REQ-027 dec_ready = 0 with dec_valid = 1: head and all dec_* outputs held stable.
REQ-028 Redirect cycle: fetch_pc <= redirect_pc; FIFO and PC side queue flushed (occupancy 0); no request issued; no pop; drop count <= outstanding - (imem_rsp_valid ? 1 : 0); outstanding follows REQ-021/023 accounting.
REQ-029 Redirect while drop count > 0 (back-to-back redirects): drop count recomputed per REQ-028, covering all in-flight responses.
REQ-030 redirect_pc alignment is not checked; the low two bits pass through unchanged.

Reset
REQ-031 On reset (sync, high): fetch_pc = RESET_PC; occupancy, outstanding, drop count = 0; FIFO and side-queue pointers = 0.
REQ-032 During and on the cycle after reset: imem_req_valid = 0 during reset; dec_valid = 0, dec_instr = NOP_INSTR, dec_pc = 0, dec_pcplus4 = 0.
REQ-033 Reset asserted mid-operation SHALL discard all queued and in-flight instructions; responses arriving after reset release are not counted or accepted beyond those requested after release.

Verification
REQ-034 Reset release, imem ready always, 1-cycle response, dec_ready = 1 -> dec_pc sequence 0x0, 0x4, 0x8 on consecutive cycles, dec_pcplus4 = dec_pc + 4, first dec_valid 2 cycles after first request.
REQ-035 dec_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests accepted, occupancy 4, imem_req_valid = 0, head 0x0 held stable; on dec_ready = 1 fetch resumes in order.
REQ-036 3-cycle imem latency, 2 outstanding, redirect_valid with redirect_pc = 0x100 -> both stale responses dropped, dec_valid low until 0x100, then 0x100, 0x104 delivered; no stale PC ever on dec_pc.
REQ-037 Redirect same cycle as a response and a pop -> response dropped, pop not taken, dec_valid = 0 that cycle, next fetch at redirect_pc.
REQ-038 fetch_pc = 0xFFFF_FFFC (XLEN = 32) -> dec_pcplus4 = 0x0, next request address 0x0.
REQ-039 Reset asserted with 3 entries queued and 1 outstanding -> next cycle dec_valid = 0, dec_instr = 0x0000_0013, first request address = RESET_PC.
